// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the EX stage and the sequential multiply/divide unit.
// The master side presents operations; the slave side owns the HI/LO registers.
interface muldiv_seq_if;
  localparam int unsigned W    = 32;
  localparam int unsigned OP_W = 3;

  logic            req_valid;
  logic [OP_W-1:0] req_op;
  logic [W-1:0]    req_a;
  logic [W-1:0]    req_b;
  logic            kill;
  logic            req_ready;
  logic            busy;
  logic            done;
  logic [W-1:0]    hi;
  logic [W-1:0]    lo;

  modport master (
    output req_valid, req_op, req_a, req_b, kill,
    input  req_ready, busy, done, hi, lo
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, kill,
    output req_ready, busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential 32-bit multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes; signs are fixed up in a final FIX cycle.
module muldiv_seq (
  input  logic         clock,
  input  logic         reset,
  muldiv_seq_if.slave  bus
);
  localparam int unsigned W    = 32;
  localparam int unsigned CW   = 5;
  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_MULTU = OP_W'(0);
  localparam logic [OP_W-1:0] OP_MULT  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(5);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_div;
  logic          neg_lo;
  logic          neg_hi;
  logic [W-1:0]  opnd;
  logic [W-1:0]  acc_hi;
  logic [W-1:0]  acc_lo;
  logic [W-1:0]  hi_q;
  logic [W-1:0]  lo_q;
  logic          done_q;
  logic          busy_q;
  logic          ready_q;

  logic          accept_c;
  logic          signed_op_c;
  logic          a_neg_c;
  logic          b_neg_c;
  logic [W-1:0]  a_abs_c;
  logic [W-1:0]  b_abs_c;
  logic [W:0]    mul_sum_c;
  logic [W:0]    div_shift_c;
  logic [W:0]    div_diff_c;
  logic          div_ge_c;
  logic [W-1:0]  step_hi_c;
  logic [W-1:0]  step_lo_c;
  logic [2*W-1:0] prod_neg_c;

  // Operand conditioning and one iteration of the active algorithm.
  always_comb begin
    accept_c    = (state == IDLE) && bus.req_valid && !bus.kill;
    signed_op_c = (bus.req_op == OP_MULT) || (bus.req_op == OP_DIV);
    a_neg_c     = signed_op_c && bus.req_a[W-1];
    b_neg_c     = signed_op_c && bus.req_b[W-1];
    a_abs_c     = a_neg_c ? (W'(0) - bus.req_a) : bus.req_a;
    b_abs_c     = b_neg_c ? (W'(0) - bus.req_b) : bus.req_b;

    mul_sum_c   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : (W+1)'(0));
    div_shift_c = {acc_hi, acc_lo[W-1]};
    div_ge_c    = div_shift_c >= {1'b0, opnd};
    div_diff_c  = div_shift_c - {1'b0, opnd};

    step_hi_c = mul_sum_c[W:1];
    step_lo_c = {mul_sum_c[0], acc_lo[W-1:1]};
    if (is_div) begin
      step_hi_c = div_ge_c ? div_diff_c[W-1:0] : div_shift_c[W-1:0];
      step_lo_c = {acc_lo[W-2:0], div_ge_c};
    end

    prod_neg_c = (2*W)'(0) - {acc_hi, acc_lo};
  end

  // Control FSM, shadow datapath and architectural HI/LO.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      opnd    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            case (bus.req_op)
              OP_MTHI: hi_q <= bus.req_a;
              OP_MTLO: lo_q <= bus.req_a;
              OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
                state   <= RUN;
                cnt     <= '0;
                busy_q  <= 1'b1;
                ready_q <= 1'b0;
                is_div  <= bus.req_op[1];
                acc_hi  <= '0;
                if (bus.req_op[1] && (bus.req_b == '0)) begin
                  // Divide by zero: unsigned run on the raw dividend yields all-ones / dividend.
                  opnd   <= '0;
                  acc_lo <= bus.req_a;
                  neg_lo <= 1'b0;
                  neg_hi <= 1'b0;
                end else if (bus.req_op[1]) begin
                  opnd   <= b_abs_c;
                  acc_lo <= a_abs_c;
                  neg_lo <= a_neg_c ^ b_neg_c;
                  neg_hi <= a_neg_c;
                end else begin
                  opnd   <= a_abs_c;
                  acc_lo <= b_abs_c;
                  neg_lo <= a_neg_c ^ b_neg_c;
                  neg_hi <= a_neg_c ^ b_neg_c;
                end
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (bus.kill) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            acc_hi <= step_hi_c;
            acc_lo <= step_lo_c;
            cnt    <= cnt + CW'(1);
            if (cnt == CW'(31)) state <= FIX;
          end
        end
        FIX: begin
          state   <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          if (!bus.kill) begin
            done_q <= 1'b1;
            if (is_div) begin
              lo_q <= neg_lo ? (W'(0) - acc_lo) : acc_lo;
              hi_q <= neg_hi ? (W'(0) - acc_hi) : acc_hi;
            end else begin
              {hi_q, lo_q} <= neg_lo ? prod_neg_c : {acc_hi, acc_lo};
            end
          end
        end
        default: begin
          state   <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.req_ready = ready_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, signed fix-up, divide corner cases, kill/reset aborts.
module tb_muldiv_seq;
  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  muldiv_seq_if bus ();

  muldiv_seq dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one request for a single cycle; returns just after the accept edge.
  task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic k);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.kill      = k;
    step();
    bus.req_valid = 1'b0;
    bus.kill      = 1'b0;
  endtask

  // Full multi-cycle op; optional noise offers DIVU 9/2 in cycles 5 and 20. Ends in the done cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input bit noise);
    int bad;
    bad = 0;
    present(op, a, b, 1'b0);
    for (int k = 0; k <= 32; k++) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.req_ready !== 1'b0 ||
          bus.hi !== m_hi || bus.lo !== m_lo) bad++;
      bus.req_valid = noise && (k == 5 || k == 20);
      bus.req_op    = 3'd2;
      bus.req_a     = 32'd9;
      bus.req_b     = 32'd2;
      step();
    end
    bus.req_valid = 1'b0;
    check({tag, " run_cycles"}, 32'(bad), 32'd0);
    check({tag, " done"}, 32'(bus.done), 32'd1);
    check({tag, " busy"}, 32'(bus.busy), 32'd0);
    check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, " hi"}, bus.hi, eh);
    check({tag, " lo"}, bus.lo, el);
    m_hi = eh;
    m_lo = el;
  endtask

  // Watch a window of idle cycles and count any done pulse.
  task automatic no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
    end
    check({tag, " no_done"}, 32'(seen), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_hi    = '0;
    m_lo    = '0;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.kill      = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst hi", bus.hi, 32'h0);
    check("rst lo", bus.lo, 32'h0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst ready", 32'(bus.req_ready), 32'd1);

    run_op("multu_max", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    step();
    check("multu_max done_width", 32'(bus.done), 32'd0);

    run_op("mult_neg", 3'd1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("divu_zero", 3'd2, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 1'b0);
    run_op("div_zero_neg", 3'd3, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);
    run_op("div_wrap", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    run_op("divu_100_7", 3'd2, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    // MTHI/MTLO then a killed multiply.
    present(3'd4, 32'h1234, 32'h0, 1'b0);
    check("mthi hi", bus.hi, 32'h1234);
    check("mthi busy", 32'(bus.busy), 32'd0);
    check("mthi done", 32'(bus.done), 32'd0);
    present(3'd5, 32'h5678, 32'h0, 1'b0);
    check("mtlo lo", bus.lo, 32'h5678);
    m_hi = 32'h1234;
    m_lo = 32'h5678;
    present(3'd0, 32'd3, 32'd5, 1'b0);
    for (int k = 1; k <= 10; k++) step();
    bus.kill = 1'b1;
    step();
    bus.kill = 1'b0;
    check("kill_run busy", 32'(bus.busy), 32'd0);
    check("kill_run ready", 32'(bus.req_ready), 32'd1);
    check("kill_run hi", bus.hi, 32'h1234);
    check("kill_run lo", bus.lo, 32'h5678);
    no_done("kill_run", 40);

    // Kill alongside a request in IDLE drops it, MTHI included.
    present(3'd4, 32'hAAAA, 32'h0, 1'b1);
    check("kill_idle mthi hi", bus.hi, 32'h1234);
    present(3'd0, 32'd3, 32'd5, 1'b1);
    check("kill_idle mul busy", 32'(bus.busy), 32'd0);
    no_done("kill_idle", 36);

    // Reserved opcode has no effect.
    present(3'd7, 32'hDEAD, 32'hBEEF, 1'b0);
    check("op7 busy", 32'(bus.busy), 32'd0);
    check("op7 hi", bus.hi, 32'h1234);
    check("op7 lo", bus.lo, 32'h5678);

    // Kill in the FIX cycle aborts the write.
    present(3'd0, 32'd2, 32'd2, 1'b0);
    for (int k = 1; k <= 32; k++) step();
    bus.kill = 1'b1;
    step();
    bus.kill = 1'b0;
    check("kill_fix done", 32'(bus.done), 32'd0);
    check("kill_fix busy", 32'(bus.busy), 32'd0);
    check("kill_fix hi", bus.hi, 32'h1234);
    check("kill_fix lo", bus.lo, 32'h5678);
    no_done("kill_fix", 4);

    // Requests while busy are ignored; a request in the done cycle is accepted.
    run_op("busy_ignore", 3'd0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b1);
    run_op("b2b_divu", 3'd2, 32'd9, 32'd2, 32'd1, 32'd4, 1'b0);
    bus.kill = 1'b1;
    step();
    bus.kill = 1'b0;
    check("kill_done hi", bus.hi, 32'd1);
    check("kill_done lo", bus.lo, 32'd4);

    // Reset in the middle of a multiply.
    present(3'd1, 32'd5, 32'hFFFFFFFE, 1'b0);
    for (int k = 1; k <= 17; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid hi", bus.hi, 32'h0);
    check("rst_mid lo", bus.lo, 32'h0);
    check("rst_mid busy", 32'(bus.busy), 32'd0);
    check("rst_mid done", 32'(bus.done), 32'd0);
    no_done("rst_mid", 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 clock  in  1  sole clock; all state changes on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 req_valid  in  1  EX presents an operation this cycle.
REQ-004 req_op  in  3  0=MULTU, 1=MULT, 2=DIVU, 3=DIV, 4=MTHI, 5=MTLO; 6 and 7 are ignored (no effect).
REQ-005 req_a  in  32  rs value (multiplicand / dividend / MTHI or MTLO source).
REQ-006 req_b  in  32  rt value (multiplier / divisor).
REQ-007 kill  in  1  ME flush; aborts the in-flight or presented operation.
REQ-008 req_ready  out  1  equals !busy; a request is accepted only when req_valid & req_ready & !kill.
REQ-009 busy  out  1  a multi-cycle operation is in flight.
REQ-010 done  out  1  one-cycle pulse; new hi/lo are visible in the same cycle.
REQ-011 hi  out  32  architectural HI register.
REQ-012 lo  out  32  architectural LO register.

Function
REQ-013 The block SHALL implement states IDLE, RUN and FIX.
- IDLE to RUN on an accepted MUL/DIV op.
- RUN to FIX when the iteration counter reaches 31.
- FIX to IDLE unconditionally.
REQ-014 MULT and DIV SHALL latch |req_a| and |req_b| at accept, together with the required sign flags.
- Quotient sign = a[31] ^ b[31].
- Remainder and DIV product sign follow the rule for the op: remainder sign = a[31]; product sign = a[31] ^ b[31].
REQ-015 Multiply SHALL be radix-2 shift-add over exactly 32 RUN cycles with no early-out, giving a 64-bit product {hi,lo}.
REQ-016 Divide SHALL be restoring, one quotient bit per RUN cycle over exactly 32 cycles; quotient goes to lo, remainder to hi.
REQ-017 FIX SHALL apply two's-complement negation per the sign flags and write hi/lo.
- Results are computed in shadow registers; hi/lo are untouched until the FIX edge.
REQ-018 Latency: with the accept edge numbered 0, hi/lo update, done=1 and busy=0 SHALL all be observed after edge 33.
- busy=1 after edges 0 through 32.
REQ-019 Divide by zero SHALL complete with normal latency and give lo=0xFFFFFFFF, hi=req_a (raw), for both DIV and DIVU.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0 (32-bit wrap).
REQ-021 MTHI/MTLO accepted in IDLE SHALL write hi/lo at the accept edge.
- busy stays 0 and done stays 0.
REQ-022 req_valid while busy SHALL be ignored with no side effects; EX is responsible for restarting the instruction.
REQ-023 kill while busy SHALL return the block to IDLE at the next edge.
- hi/lo keep their prior values; no done pulse.
- req_ready=1 in the following cycle.
REQ-024 kill together with req_valid in IDLE SHALL drop the request, including MTHI/MTLO.
REQ-025 kill in the FIX cycle SHALL abort; no write and no done.
- kill in the done cycle has no effect; that result is already committed.
REQ-026 A request presented in the done cycle SHALL be accepted; back-to-back operations are allowed.

Reset
REQ-027 reset SHALL force state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0 and clear shadow/sign registers.
- reset overrides kill and req_valid.
REQ-028 reset asserted mid-operation SHALL abort it with no done pulse; outputs follow REQ-027 after that edge.

Verification
REQ-029 MULTU 0xFFFFFFFF * 0xFFFFFFFF -> after edge 33: hi=0xFFFFFFFE, lo=0x00000001, done high exactly one cycle, busy high after edges 0-32.
REQ-030 MULT 0xFFFFFFFD(-3) * 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV 0xFFFFFFF9(-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-031 DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=7.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 MTHI 0x1234 then MTLO 0x5678, then MULTU 3*5, with kill asserted in RUN cycle 10 -> hi=0x1234, lo=0x5678, no done, req_ready=1 in the next cycle.
REQ-033 MULTU 2*3 accepted, then DIVU 9/2 offered at cycles 5 and 20 -> both ignored; hi=0, lo=6 at done.
- DIVU 9/2 offered again in the done cycle -> accepted; 34 edges later lo=4, hi=1.
REQ-034 reset asserted in RUN cycle 17 of MULT -> hi=lo=0, busy=0, no done pulse at any later cycle.
